// File: rtl/aes128_iter_ctrl.sv
// aes128_iter_ctrl -- iterative AES-128 encryption controller.
//
// One cipher round per clock through a single shared round datapath
// (SubBytes, ShiftRows, MixColumns, AddRoundKey). The round key is expanded
// on the fly, one key per cycle, alongside the state.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   host handshake for plaintext + key
//   plaintext, key        [0:127], byte 0 on [0:7] (FIPS-197 byte order)
//   out_valid / out_ready consumer handshake for ciphertext
//   ciphertext            [0:127] result, held stable until accepted
//   busy                  high while a block is being ciphered
//   round_idx             round about to be computed; NUM_ROUNDS+1 when done
module aes128_iter_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] plaintext,
  input  logic [0:127] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] ciphertext,
  output logic         busy,
  output logic [3:0]   round_idx
);

  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} fsm_t;

  // With NUM_ROUNDS = 15 the DONE value NUM_ROUNDS+1 wraps to 0 in 4 bits.
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      p  = p ^ (b[i] ? aa : 8'h00);
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box computed as GF(2^8) inverse (x^254, so 0 maps to 0) plus the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // State bytes are column-major: byte 4*c+r sits at row r, column c.
  function automatic logic [0:127] sub_shift(input logic [0:127] s);
    logic [0:127] r;
    r = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        r[8*(4*c+w) +: 8] = sbox(s[8*(4*((c+w)%4)+w) +: 8]);
      end
    end
    return r;
  endfunction

  function automatic logic [0:127] mix_columns(input logic [0:127] s);
    logic [0:127] r;
    logic [7:0]   a0, a1, a2, a3;
    r = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c+8 +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      r[32*c    +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[32*c+8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[32*c+16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[32*c+24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  // One key-schedule step: SubWord(RotWord(w3)) ^ Rcon, then the w0..w3 XOR chain.
  function automatic logic [0:127] expand_key(input logic [0:127] k, input logic [7:0] rc);
    logic [0:31] t, w0, w1, w2, w3;
    t  = {sbox(k[104 +: 8]) ^ rc, sbox(k[112 +: 8]), sbox(k[120 +: 8]), sbox(k[96 +: 8])};
    w0 = k[0:31]   ^ t;
    w1 = k[32:63]  ^ w0;
    w2 = k[64:95]  ^ w1;
    w3 = k[96:127] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  fsm_t         fsm_r, fsm_nxt_s;
  logic [0:127] state_r, key_r, ct_r;
  logic [7:0]   rcon_r;
  logic [3:0]   round_r;
  logic         out_valid_r, busy_r;
  logic         in_ready_s, accept_s, last_s;
  logic [0:127] sr_s, next_key_s, round_out_s;

  assign accept_s = in_valid & in_ready_s;
  assign last_s   = (round_r == LAST_ROUND);

  // Shared round datapath; the final round skips MixColumns.
  always_comb begin
    sr_s       = sub_shift(state_r);
    next_key_s = expand_key(key_r, rcon_r);
    if (last_s) begin
      round_out_s = sr_s ^ next_key_s;
    end else begin
      round_out_s = mix_columns(sr_s) ^ next_key_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_r <= IDLE;
    end else begin
      fsm_r <= fsm_nxt_s;
    end
  end

  // FSM next-state logic; DONE can reload directly so there is no bubble.
  always_comb begin
    fsm_nxt_s = fsm_r;
    case (fsm_r)
      IDLE:    if (accept_s) fsm_nxt_s = ROUND; else fsm_nxt_s = IDLE;
      ROUND:   if (last_s) fsm_nxt_s = DONE; else fsm_nxt_s = ROUND;
      DONE: begin
        if (out_ready) begin
          if (in_valid) fsm_nxt_s = ROUND; else fsm_nxt_s = IDLE;
        end else begin
          fsm_nxt_s = DONE;
        end
      end
      default: fsm_nxt_s = IDLE;
    endcase
  end

  // FSM output logic: ready in IDLE, or in DONE when the result leaves this cycle.
  always_comb begin
    in_ready_s = 1'b0;
    case (fsm_r)
      IDLE:    in_ready_s = 1'b1;
      DONE:    in_ready_s = out_ready;
      ROUND:   in_ready_s = 1'b0;
      default: in_ready_s = 1'b0;
    endcase
  end

  // Datapath and registered status: load on accept, one round per cycle in ROUND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= 128'h0;
      key_r       <= 128'h0;
      ct_r        <= 128'h0;
      rcon_r      <= 8'h01;
      round_r     <= 4'd0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      busy_r <= (fsm_nxt_s == ROUND);
      if (accept_s) begin
        state_r     <= plaintext ^ key;
        key_r       <= key;
        rcon_r      <= 8'h01;
        round_r     <= 4'd1;
        out_valid_r <= 1'b0;
      end else begin
        case (fsm_r)
          ROUND: begin
            state_r <= round_out_s;
            key_r   <= next_key_s;
            rcon_r  <= xtime(rcon_r);
            round_r <= round_r + 4'd1;
            if (last_s) begin
              ct_r        <= round_out_s;
              out_valid_r <= 1'b1;
            end
          end
          DONE: begin
            if (out_ready) begin
              out_valid_r <= 1'b0;
              round_r     <= 4'd0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // in_ready is forced low for as long as reset is held.
  assign in_ready   = in_ready_s & rst_n;
  assign out_valid  = out_valid_r;
  assign ciphertext = ct_r;
  assign busy       = busy_r;
  assign round_idx  = round_r;

endmodule

// File: doc/aes128_iter_ctrl.md
Name: aes128_iter_ctrl

Overview:
- Iterative AES-128 encryption controller.
- Performs one cipher round per clock through a single shared round datapath: SubBytes, ShiftRows, MixColumns, AddRoundKey. The MixColumns stage is the team's 128-bit MixColumns instance.
- Expands the round key on the fly, one key per cycle.
- Sequences NUM_ROUNDS rounds; the last round bypasses MixColumns.
- Sits between the host-side block stream and the cipher datapath, with valid/ready on both sides.

Parameters:
- NUM_ROUNDS, default 10, total rounds including the final round. Must be 10 for FIPS-197 AES-128. Legal range is 2..15, used for reduced-round debug only.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  plaintext and key presented.
- in_ready  output  1  controller can accept a block this cycle.
- plaintext  input  [0:127]  input block; byte 0 on [0:7].
- key  input  [0:127]  cipher key; byte 0 on [0:7].
- out_valid  output  1  ciphertext is valid.
- out_ready  input  1  consumer accepts the ciphertext.
- ciphertext  output  [0:127]  result; byte 0 on [0:7].
- busy  output  1  a block is in flight (ROUND state).
- round_idx  output  4  current round number, 0 when idle.

Behaviour:
- All buses use the ascending [0:127] convention. Byte order is the FIPS-197 input/output order. The state fed to the shared datapath uses the layout the team's round submodules expect.
- Reset (rst_n low, asynchronous):
  - State → IDLE.
  - state_reg, key_reg, ciphertext → 0.
  - rcon_reg → 8'h01.
  - round_idx → 0.
  - out_valid, busy → 0.
  - in_ready → 0 while rst_n is low, then 1 in IDLE.
- FSM states:
  - IDLE: in_ready = 1. On in_valid & in_ready:
    - state_reg ← plaintext ^ key (initial AddRoundKey).
    - key_reg ← key; round_idx ← 1; rcon_reg ← 8'h01.
    - Go to ROUND.
  - ROUND: busy = 1, in_ready = 0. Each cycle:
    - next_key = expand(key_reg, rcon_reg), using standard RotWord/SubWord/Rcon on word 3, with the XOR chain w0..w3.
    - If round_idx < NUM_ROUNDS: state_reg ← MixColumns(ShiftRows(SubBytes(state_reg))) ^ next_key.
    - If round_idx == NUM_ROUNDS: the same without MixColumns.
    - key_reg ← next_key.
    - rcon_reg ← xtime(rcon_reg): left shift, then XOR with 8'h1b if bit 7 was set. Past round 8 this gives 1b, 36, 6c, …
    - round_idx increments.
    - On the last round: ciphertext ← result, out_valid ← 1, go to DONE.
  - DONE: out_valid = 1, and ciphertext is held stable until out_valid & out_ready.
    - in_ready = out_ready, so back-to-back operation is allowed.
    - On out_ready without in_valid: out_valid ← 0, round_idx ← 0, go to IDLE.
    - On out_ready with in_valid: the new block loads exactly as in IDLE, out_valid ← 0, go to ROUND. No bubble cycle.
- Latency:
  - Accepting edge is E0. Rounds occur on E1..E_NUM_ROUNDS.
  - out_valid rises after edge E_NUM_ROUNDS, which is 10 cycles for AES-128.
  - Throughput is one block per NUM_ROUNDS+1 cycles with back-to-back traffic.
- Inputs:
  - plaintext and key are sampled only on the accepting edge.
  - Changes to them during ROUND or DONE have no effect.
  - in_valid during ROUND is ignored; in_ready = 0 and nothing is dropped silently, because the producer must hold in_valid.
- Outputs:
  - out_valid never deasserts without out_ready.
  - ciphertext changes only when out_valid rises.
- Reset asserted mid-ROUND or in DONE: the block is discarded, all outputs return to reset values immediately (asynchronous), and no partial ciphertext is emitted.
- round_idx equals the round about to be computed while in ROUND, and NUM_ROUNDS+1 in DONE.

Test Plan:
- FIPS-197 App. B: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c, out_ready = 1 → out_valid exactly 10 cycles after accept, ct 3925841d02dc09fbdc118597196a0b32, busy high for 10 cycles.
- FIPS-197 App. C.1: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f → ct 69c4e0d86a7b0430d8cdb78070b4c55a. Check round_idx 1..10 in ROUND and 11 in DONE.
- Backpressure: out_ready held low for 7 cycles after completion → out_valid and ciphertext stable for all 7 cycles, in_ready = 0, and a new in_valid is not accepted. Release → one-cycle handshake, then return to IDLE.
- Back-to-back: App. B block then App. C.1 block, with in_valid asserted in DONE together with out_ready = 1 → second block accepted on the same edge, second ct appears 11 cycles after the first, and both ciphertexts are correct.
- Reset mid-round: drop rst_n at round 5 → out_valid = 0, busy = 0, ciphertext = 0 asynchronously. After release, a fresh App. C.1 block yields the correct ct.
- Input hold: change plaintext and key every cycle during ROUND → ciphertext matches the values sampled at accept.
